// File: rtl/boot_loader_pkg.sv
// Shared types for the boot loader: frame-parser states and the full-word write enable.
package kgp_boot_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    RUN,
    ERR
  } state_t;

  localparam logic [3:0] IMEM_WE_ALL = 4'b1111;
  localparam int         LEN_W       = 16;

endpackage

// File: rtl/boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface boot_loader_if #(
  parameter int ADDR_W = 32
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [3:0]        imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_din;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_din
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_din
  );
endinterface

// File: rtl/boot_loader_byte_packer.sv
// Packs four big-endian bytes into a 32-bit word; word_done marks the cycle the 4th byte arrives.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0]  count_reg;
  logic [23:0] shift_reg;

  // The completed word is formed combinationally so the caller can register it on the same edge.
  assign word      = {shift_reg, data};
  assign word_done = valid && (count_reg == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_reg <= 2'd0;
      shift_reg <= 24'd0;
    end else if (valid) begin
      count_reg <= count_reg + 2'd1;
      shift_reg <= {shift_reg[15:0], data};
    end
  end
endmodule

// File: rtl/boot_loader.sv
// Receives a length-prefixed, XOR-checked program frame and writes it word by word into
// instruction memory, then raises start (or err on a bad frame) until the next reset.
module boot_loader
  import kgp_boot_pkg::*;
#(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic          clk,
  input  logic          rst,
  boot_loader_if.slave  bus,
  output logic          start,
  output logic          busy,
  output logic          err
);
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MAX_WORDS);

  state_t             state_reg, state_next;
  logic [7:0]         len_hi_reg;
  logic [LEN_W-1:0]   len_reg;
  logic [7:0]         xor_acc_reg;
  logic [LEN_W-1:0]   word_idx_reg;
  logic [3:0]         we_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [31:0]        din_reg;

  logic               rx_ready;
  logic               accept;
  logic [LEN_W-1:0]   len_full;
  logic               last_word;
  logic [31:0]        packed_word;
  logic               word_done;

  assign rx_ready  = (state_reg == LEN_HI) || (state_reg == LEN_LO) ||
                     (state_reg == DATA)   || (state_reg == CSUM);
  assign accept    = bus.rx_valid && rx_ready;
  assign len_full  = {len_hi_reg, bus.rx_data};
  assign last_word = (word_idx_reg == len_reg - 16'd1);

  assign bus.rx_ready  = rx_ready;
  assign bus.imem_we   = we_reg;
  assign bus.imem_addr = addr_reg;
  assign bus.imem_din  = din_reg;

  assign start = (state_reg == RUN);
  assign err   = (state_reg == ERR);
  assign busy  = (state_reg == LEN_LO) || (state_reg == DATA) || (state_reg == CSUM);

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .valid     (accept && (state_reg == DATA)),
    .data      (bus.rx_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LEN_HI: if (accept) state_next = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_full == '0)                  state_next = CSUM;
          else if ({1'b0, len_full} > MAX_LEN) state_next = ERR;
          else                                 state_next = DATA;
        end
      end
      DATA:   if (word_done && last_word) state_next = CSUM;
      CSUM: begin
        if (accept) state_next = (bus.rx_data == xor_acc_reg) ? RUN : ERR;
      end
      RUN:    state_next = RUN;
      ERR:    state_next = ERR;
      default: state_next = LEN_HI;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= LEN_HI;
      len_hi_reg   <= 8'd0;
      len_reg      <= '0;
      xor_acc_reg  <= 8'd0;
      word_idx_reg <= '0;
      we_reg       <= 4'd0;
      addr_reg     <= '0;
      din_reg      <= 32'd0;
    end else begin
      state_reg <= state_next;
      we_reg    <= 4'd0;
      if (accept && (state_reg == LEN_HI)) len_hi_reg <= bus.rx_data;
      if (accept && (state_reg == LEN_LO)) len_reg <= len_full;
      if (accept && (state_reg == DATA)) xor_acc_reg <= xor_acc_reg ^ bus.rx_data;
      // Write register is independent of the packer, so the next byte may arrive meanwhile.
      if (word_done) begin
        we_reg   <= IMEM_WE_ALL;
        addr_reg <= ADDR_W'(word_idx_reg);
        din_reg  <= packed_word;
        if (!last_word) word_idx_reg <= word_idx_reg + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frame loads, checksum and length errors, aborts and gapped input.
module tb_boot_loader;
  import kgp_boot_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start, busy, err;
  int   total = 0;
  int   bad = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_din_q[$];

  boot_loader_if #(.ADDR_W(32)) bus ();

  boot_loader #(.MAX_WORDS(1024), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .start (start),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.imem_we !== 4'h0) begin
      total++;
      if (bus.imem_we !== 4'hF) begin
        bad++;
        $display("FAIL we_value: got %b want 1111", bus.imem_we);
      end
      $display("write addr=%0h din=%h", bus.imem_addr, bus.imem_din);
      wr_addr_q.push_back(bus.imem_addr);
      wr_din_q.push_back(bus.imem_din);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] f[$], input int gap);
    foreach (f[i]) send_byte(f[i], gap);
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_addr_q.delete();
    wr_din_q.delete();
  endtask

  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total += 7;
    if (bus.imem_we !== 4'h0) begin bad++; $display("FAIL reset_we: got %b want 0000", bus.imem_we); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    if (bus.imem_din !== 32'h0) begin bad++; $display("FAIL reset_din: got %h want 0", bus.imem_din); end
    if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", err); end
    if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.rx_ready); end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [7:0] f[$];
    do_reset();
    send_byte(8'h00, 0);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    f = '{8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(f, 0);
    @(negedge clk);
    total += 3;
    if (bus.imem_we !== 4'hF) begin bad++; $display("FAIL single_we_latency: got %b want 1111", bus.imem_we); end
    if (bus.imem_addr !== 32'h0) begin bad++; $display("FAIL single_addr: got %h want 0", bus.imem_addr); end
    if (bus.imem_din !== 32'hDEADBEEF) begin bad++; $display("FAIL single_din: got %h want deadbeef", bus.imem_din); end
    send_byte(8'h22, 0);
    @(negedge clk);
    total += 5;
    if (wr_din_q.size() != 1) begin bad++; $display("FAIL single_write_count: got %0d want 1", wr_din_q.size()); end
    if (start !== 1'b1) begin bad++; $display("FAIL single_start: got %b want 1", start); end
    if (err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL single_ready: got %b want 0", bus.rx_ready); end
  endtask

  task automatic test_two(input int gap, input logic [7:0] csum, input logic good);
    logic [7:0] f[$];
    do_reset();
    f = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hA5, 8'hA5, 8'hA5, csum};
    send_frame(f, gap);
    repeat (2) @(negedge clk);
    total += 4;
    if (wr_din_q.size() != 2) begin
      bad++;
      $display("FAIL two_write_count gap=%0d: got %0d want 2", gap, wr_din_q.size());
    end else begin
      total += 3;
      if (wr_addr_q[0] !== 32'd0 || wr_addr_q[1] !== 32'd1) begin
        bad++; $display("FAIL two_addr gap=%0d: got %0h,%0h want 0,1", gap, wr_addr_q[0], wr_addr_q[1]);
      end
      if (wr_din_q[0] !== 32'h11223344) begin bad++; $display("FAIL two_din0: got %h want 11223344", wr_din_q[0]); end
      if (wr_din_q[1] !== 32'hA5A5A5A5) begin bad++; $display("FAIL two_din1: got %h want a5a5a5a5", wr_din_q[1]); end
    end
    if (start !== good) begin bad++; $display("FAIL two_start csum=%h: got %b want %b", csum, start, good); end
    if (err !== !good) begin bad++; $display("FAIL two_err csum=%h: got %b want %b", csum, err, !good); end
    if (busy !== 1'b0) begin bad++; $display("FAIL two_busy csum=%h: got %b want 0", csum, busy); end
  endtask

  task automatic test_too_long();
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    total += 3;
    if (err !== 1'b1) begin bad++; $display("FAIL long_err: got %b want 1", err); end
    if (busy !== 1'b0) begin bad++; $display("FAIL long_busy: got %b want 0", busy); end
    if (bus.rx_ready !== 1'b0) begin bad++; $display("FAIL long_ready: got %b want 0", bus.rx_ready); end
    send_byte(8'hDE, 0);
    send_byte(8'hAD, 0);
    @(negedge clk);
    total += 3;
    if (err !== 1'b1) begin bad++; $display("FAIL long_err_sticky: got %b want 1", err); end
    if (start !== 1'b0) begin bad++; $display("FAIL long_start: got %b want 0", start); end
    if (wr_din_q.size() != 0) begin bad++; $display("FAIL long_writes: got %0d want 0", wr_din_q.size()); end
  endtask

  task automatic test_max_len();
    do_reset();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    total += 2;
    if (err !== 1'b0) begin bad++; $display("FAIL maxlen_err: got %b want 0", err); end
    if (bus.rx_ready !== 1'b1) begin bad++; $display("FAIL maxlen_ready: got %b want 1", bus.rx_ready); end
  endtask

  task automatic test_zero();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h00, 8'h00, 8'h00};
    send_frame(f, 0);
    repeat (2) @(negedge clk);
    total += 3;
    if (start !== 1'b1) begin bad++; $display("FAIL zero_start: got %b want 1", start); end
    if (err !== 1'b0) begin bad++; $display("FAIL zero_err: got %b want 0", err); end
    if (wr_din_q.size() != 0) begin bad++; $display("FAIL zero_writes: got %0d want 0", wr_din_q.size()); end
  endtask

  task automatic test_abort();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD};
    send_frame(f, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total += 2;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    if (wr_din_q.size() != 0) begin bad++; $display("FAIL abort_writes: got %0d want 0", wr_din_q.size()); end
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send_frame(f, 0);
    repeat (2) @(negedge clk);
    total += 2;
    if (start !== 1'b1) begin bad++; $display("FAIL abort_start: got %b want 1", start); end
    if (wr_din_q.size() != 1) begin
      bad++; $display("FAIL abort_reload_count: got %0d want 1", wr_din_q.size());
    end else begin
      total++;
      if (wr_addr_q[0] !== 32'd0 || wr_din_q[0] !== 32'hDEADBEEF) begin
        bad++; $display("FAIL abort_reload: got %0h:%h want 0:deadbeef", wr_addr_q[0], wr_din_q[0]);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE};
    send_frame(f, 0);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'hEF;
    rst = 1'b0;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total += 3;
    if (bus.imem_we !== 4'h0) begin bad++; $display("FAIL pending_we: got %b want 0000", bus.imem_we); end
    if (wr_din_q.size() != 0) begin bad++; $display("FAIL pending_writes: got %0d want 0", wr_din_q.size()); end
    if (busy !== 1'b0) begin bad++; $display("FAIL pending_busy: got %b want 0", busy); end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_single();
    test_two(0, 8'h44, 1'b1);
    test_two(0, 8'h45, 1'b0);
    test_two(1, 8'h44, 1'b1);
    test_too_long();
    test_max_len();
    test_zero();
    test_abort();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
